// File: rtl/dispatcher.sv
// Routes an indexed input stream into COUNT independent circular FIFOs, each
// draining through its own valid/ready port. Out-of-range indices are swallowed.
//
// state   | meaning
// EMPTY   | occupancy == 0, out_valid low
// PARTIAL | 0 < occupancy < DEPTH
// FULL    | occupancy == DEPTH, pushes refused
module dispatcher #(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  parameter int DEPTH = 4,
  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IW-1:0]    in_index,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic [COUNT-1:0] out_valid,
  input  logic [COUNT-1:0] out_ready,
  output logic [WIDTH-1:0] out_values [COUNT],
  output logic [CW-1:0]    occupancy [COUNT],
  output logic             dropped
);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_t;

  fifo_state_t      state_q [COUNT];
  fifo_state_t      state_d [COUNT];
  logic [CW-1:0]    cnt_q   [COUNT];
  logic [CW-1:0]    cnt_d   [COUNT];
  logic [PW-1:0]    rd_ptr  [COUNT];
  logic [PW-1:0]    wr_ptr  [COUNT];
  logic [WIDTH-1:0] mem     [COUNT][DEPTH];

  logic             in_range;
  logic             sel_full;
  logic             accept;
  logic [COUNT-1:0] push;
  logic [COUNT-1:0] pop;

  // When COUNT fills the index space every index is legal.
  if (COUNT == (1 << IW)) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = (in_index < IW'(COUNT));
  end

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < COUNT; i++)
      if (in_index == IW'(i)) sel_full = (state_q[i] == FULL);
  end

  assign in_ready = !reset && (!in_range || !sel_full);
  assign accept   = in_valid && in_ready;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int i = 0; i < COUNT; i++) begin
      push[i]      = accept && in_range && (in_index == IW'(i));
      pop[i]       = !reset && out_valid[i] && out_ready[i];
      out_valid[i] = (state_q[i] != EMPTY);
      out_values[i] = out_valid[i] ? mem[i][rd_ptr[i]] : '0;
      occupancy[i]  = cnt_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < COUNT; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case ({push[i], pop[i]})
        2'b10: begin
          cnt_d[i]   = cnt_q[i] + CW'(1);
          state_d[i] = (cnt_q[i] == CW'(DEPTH - 1)) ? FULL : PARTIAL;
        end
        2'b01: begin
          cnt_d[i]   = cnt_q[i] - CW'(1);
          state_d[i] = (cnt_q[i] == CW'(1)) ? EMPTY : PARTIAL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dropped <= 1'b0;
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= EMPTY;
        cnt_q[i]   <= '0;
        rd_ptr[i]  <= '0;
        wr_ptr[i]  <= '0;
      end
    end else begin
      dropped <= accept && !in_range;
      for (int i = 0; i < COUNT; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
      end
    end
  end

  // Storage needs no reset; push is already blocked while reset is high.
  always_ff @(posedge clock) begin
    for (int i = 0; i < COUNT; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_value;
  end

endmodule

// File: tb/tb_dispatcher.sv
// Drives a COUNT=4 and a COUNT=3 dispatcher with identical stimulus and checks
// both against queue-based reference models.
module tb_dispatcher;
  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [1:0] in_index;
  logic [7:0] in_value;
  logic [3:0] out_ready;

  logic       a_ready, b_ready;
  logic [3:0] a_valid;
  logic [2:0] b_valid;
  logic [7:0] a_vals [4];
  logic [7:0] b_vals [3];
  logic [2:0] a_occ  [4];
  logic [2:0] b_occ  [3];
  logic       a_drop, b_drop;

  int nvec = 0;
  int nmis = 0;

  logic [7:0] mq [8][$];

  dispatcher #(.WIDTH(8), .COUNT(4), .DEPTH(DEPTH)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_index(in_index),
    .in_value(in_value), .in_ready(a_ready), .out_valid(a_valid),
    .out_ready(out_ready), .out_values(a_vals), .occupancy(a_occ),
    .dropped(a_drop)
  );

  dispatcher #(.WIDTH(8), .COUNT(3), .DEPTH(DEPTH)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_index(in_index),
    .in_value(in_value), .in_ready(b_ready), .out_valid(b_valid),
    .out_ready(out_ready[2:0]), .out_values(b_vals), .occupancy(b_occ),
    .dropped(b_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic [1:0] idx,
                      input logic [7:0] val, input logic [3:0] ordy);
    logic       er    [2];
    logic [3:0] epush [2];
    logic [3:0] epop  [2];
    logic       edrop [2];
    reset = rst; in_valid = v; in_index = idx; in_value = val; out_ready = ordy;
    #1;
    for (int d = 0; d < 2; d++) begin
      int cnt;
      string pfx;
      cnt = (d == 0) ? 4 : 3;
      pfx = (d == 0) ? "a" : "b";
      epush[d] = '0; epop[d] = '0; edrop[d] = 1'b0;
      if (rst) er[d] = 1'b0;
      else if (int'(idx) >= cnt) er[d] = 1'b1;
      else er[d] = (mq[d*4 + int'(idx)].size() < DEPTH);
      chk($sformatf("%s_in_ready", pfx), (d == 0) ? a_ready : b_ready, er[d]);
      if (v && er[d]) begin
        if (int'(idx) < cnt) epush[d][idx] = 1'b1;
        else edrop[d] = 1'b1;
      end
      for (int i = 0; i < cnt; i++)
        if (!rst && ordy[i] && mq[d*4 + i].size() > 0) epop[d][i] = 1'b1;
    end
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      int cnt;
      string pfx;
      logic [3:0] ev;
      cnt = (d == 0) ? 4 : 3;
      pfx = (d == 0) ? "a" : "b";
      ev = '0;
      for (int i = 0; i < cnt; i++) begin
        logic [7:0] head;
        if (rst) mq[d*4 + i].delete();
        else begin
          if (epop[d][i]) void'(mq[d*4 + i].pop_front());
          if (epush[d][i]) mq[d*4 + i].push_back(val);
        end
        ev[i] = (mq[d*4 + i].size() > 0);
        head  = ev[i] ? mq[d*4 + i][0] : 8'h00;
        chk($sformatf("%s_occ%0d", pfx, i), (d == 0) ? a_occ[i] : b_occ[i],
            mq[d*4 + i].size());
        chk($sformatf("%s_val%0d", pfx, i), (d == 0) ? a_vals[i] : b_vals[i], head);
      end
      chk($sformatf("%s_out_valid", pfx), (d == 0) ? a_valid : {1'b0, b_valid}, ev);
      chk($sformatf("%s_dropped", pfx), (d == 0) ? a_drop : b_drop,
          rst ? 1'b0 : edrop[d]);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_index = '0; in_value = '0; out_ready = '0;

    // reset held two cycles with a pending offer
    step(1, 1, 0, 8'h55, 4'h0);
    step(1, 1, 0, 8'h55, 4'h0);
    chk("rst_valid", a_valid, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      chk("rst_occ", a_occ[i], 0);
      chk("rst_vals", a_vals[i], 0);
    end

    // routing and order
    step(0, 1, 0, 8'd1, 4'h0);
    step(0, 1, 1, 8'd2, 4'h0);
    step(0, 1, 2, 8'd4, 4'h0);
    step(0, 1, 3, 8'd8, 4'h0);
    step(0, 1, 0, 8'd9, 4'h0);
    chk("rt_valid", a_valid, 4'b1111);
    chk("rt_v0", a_vals[0], 1);
    chk("rt_v1", a_vals[1], 2);
    chk("rt_v2", a_vals[2], 4);
    chk("rt_v3", a_vals[3], 8);
    chk("rt_occ0", a_occ[0], 2);
    step(0, 0, 0, 8'd0, 4'b0001);
    chk("rt_pop_v0", a_vals[0], 9);
    chk("rt_pop_v1", a_vals[1], 2);
    chk("rt_pop_v3", a_vals[3], 8);
    chk("rt_pop_valid", a_valid, 4'b1111);
    step(0, 0, 0, 8'd0, 4'hF);

    // full / backpressure on index 2
    for (int k = 0; k < 4; k++) step(0, 1, 2, 8'(10 + k), 4'h0);
    chk("bp_occ2", a_occ[2], 4);
    in_valid = 1'b0; in_index = 2'd2; #1;
    chk("bp_rdy2", a_ready, 0);
    in_index = 2'd1; #1;
    chk("bp_rdy1", a_ready, 1);
    step(0, 1, 1, 8'd14, 4'h0);
    chk("bp_occ1", a_occ[1], 1);
    step(0, 1, 2, 8'd15, 4'b0100);
    chk("bp_occ2_pop", a_occ[2], 3);
    chk("bp_head2", a_vals[2], 11);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 8'd0, 4'hF);

    // wrap-around with overlapped push/pop on index 3
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) chk("wrap_head", a_vals[3], k - 1);
      step(0, 1, 3, 8'(k), (k > 1) ? 4'b1000 : 4'b0000);
      chk("wrap_occ", a_occ[3], 1);
    end
    chk("wrap_last", a_vals[3], 8);
    step(0, 0, 0, 8'd0, 4'b1000);
    chk("wrap_empty", a_occ[3], 0);

    // out-of-range index on the COUNT=3 build
    reset = 1'b0; in_valid = 1'b1; in_index = 2'd3; in_value = 8'hAA; out_ready = '0; #1;
    chk("oor_rdy", b_ready, 1);
    step(0, 1, 3, 8'hAA, 4'h0);
    chk("oor_drop", b_drop, 1);
    step(0, 0, 0, 8'h00, 4'h0);
    chk("oor_drop_end", b_drop, 0);
    for (int i = 0; i < 3; i++) chk("oor_occ", b_occ[i], 0);

    // reset mid-operation (index 3 already holds 8'hAA)
    step(0, 1, 0, 8'h21, 4'h0);
    step(0, 1, 0, 8'h22, 4'h0);
    step(0, 1, 1, 8'h23, 4'h0);
    step(0, 1, 3, 8'h24, 4'h0);
    step(0, 1, 3, 8'h25, 4'h0);
    chk("mid_occ3", a_occ[3], 3);
    step(1, 1, 1, 8'h77, 4'h0);
    chk("mid_valid", a_valid, 4'b0000);
    for (int i = 0; i < 4; i++) chk("mid_occ", a_occ[i], 0);

    // random traffic
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
           2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/dispatcher.md
# dispatcher

The dispatcher is the inverse of the selector. It takes one stream of WIDTH-bit values, each tagged with a destination index, and routes every value into one of COUNT per-destination FIFOs. Each FIFO drains through its own valid/ready port. In MemorEDF it sits in front of the per-core request queues, so the selector can later pick among them by index.

## Interface
- WIDTH, 8, data width of each value
- COUNT, 4, number of destinations; IW = max(1, $clog2(COUNT))
- DEPTH, 4, entries per destination FIFO; power of two, ≥ 2; CW = $clog2(DEPTH+1)
- clock  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  producer offers a value
- in_index  input  IW  destination of the offered value
- in_value  input  WIDTH  offered value
- in_ready  output  1  dispatcher accepts this cycle
- out_valid  output  COUNT  bit i: FIFO i non-empty
- out_ready  input  COUNT  bit i: consumer i pops head this cycle
- out_values  output  [WIDTH] x COUNT (unpacked)  head of FIFO i
- occupancy  output  [CW] x COUNT (unpacked)  entries currently in FIFO i
- dropped  output  1  one-cycle pulse: out-of-range index discarded

## Operation
- Push: occurs when in_valid && in_ready && in_index < COUNT. in_value is written at the tail of FIFO[in_index].
- Pop: occurs on FIFO i when out_valid[i] && out_ready[i]. The head advances.
- in_ready is combinational:
  - 0 while reset is high.
  - 1 when in_index ≥ COUNT.
  - Otherwise it is !full[in_index], where full means occupancy == DEPTH.
- in_ready depends only on registered occupancy. A full FIFO never accepts a value, even if it pops in the same cycle; there is no pass-through.
- Out-of-range index: when in_valid and in_index ≥ COUNT, the value is accepted and discarded. dropped is 1 in the next cycle only. No FIFO changes.
- Each FIFO is circular, with rd/wr pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- occupancy[i] updates as follows:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on a simultaneous push and pop.
- Simultaneous push and pop on the same non-full, non-empty FIFO: both take effect. Order is preserved.
- Push into an empty FIFO with out_ready high in the same cycle: no pop, because out_valid was 0.
- out_values[i] is the head entry when out_valid[i] = 1, and 0 otherwise.
- FIFOs are independent. Activity on one never stalls or alters another.
- Per-FIFO state: EMPTY (occupancy 0), PARTIAL, FULL (occupancy DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push reaching DEPTH.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop reaching 0.

## Timing
- Reset, sampled on a rising edge, forces every FIFO empty and all pointers to 0. out_valid = 0, occupancy = 0, out_values = 0, dropped = 0.
- In any cycle where reset is high, in_ready is 0 and no push or pop occurs.
- Reset asserted mid-operation discards all stored data at that edge. Data accepted in the same cycle as reset is lost.
- Push-to-visible latency is 1 cycle. A value accepted at edge k gives out_valid[i] = 1 and the value on out_values[i] after edge k.
- Pop-to-update latency is 1 cycle. Head, occupancy and out_valid reflect a pop after the edge that performed it.
- Throughput: one push per cycle into any destination, plus up to COUNT pops per cycle in parallel.
- in_value and in_index may change only when not accepted. The producer holds them while in_valid && !in_ready.

## Test plan
- Reset: hold reset high 2 cycles with in_valid = 1, in_index = 0, in_value = 8'h55. Require:
  - in_ready = 0 throughout.
  - After release: out_valid = 4'b0000, all occupancy = 0, out_values all 0.
- Routing, FIFO order and independence: push 1, 2, 4, 8 to indices 0, 1, 2, 3, then push 9 to index 0, with all out_ready = 0. Require:
  - One cycle after the last push: out_valid = 4'b1111, out_values = {1, 2, 4, 8}, occupancy[0] = 2.
  - Then pulse out_ready[0] only: out_values[0] = 9, other outputs unchanged.
- Full / backpressure: push 10, 11, 12, 13 to index 2 with out_ready = 0. Require:
  - occupancy[2] = 4 and in_ready = 0 for in_index = 2.
  - in_ready = 1 for in_index = 1, and a push of 14 there succeeds.
  - Offering 15 to index 2 with out_ready[2] = 1 in the same cycle is not accepted.
- Wrap-around plus simultaneous push and pop: on index 3, push 8 values 1..8 while popping from the second push onward. Require:
  - Pops return 1..8 in order.
  - occupancy[3] stays at 1 during the overlap and reaches 0 at the end.
  - No loss when the pointers wrap past 3.
- Out-of-range index (build with COUNT = 3): in_valid = 1, in_index = 3, in_value = 8'hAA. Require:
  - in_ready = 1.
  - dropped = 1 for exactly one cycle.
  - occupancy all unchanged.
- Reset mid-operation: with occupancy = {2, 1, 0, 3}, assert reset for 1 cycle while pushing to index 1. Require all occupancy = 0 and out_valid = 0 afterward.
